// File: rtl/morse_encoder.sv
// morse_encoder: keys one 6-bit character code out as timed Morse dot/dash marks.
// Optional feature macro: MORSE_TONE_EN. When it is defined, a free-running square-wave
// divider gates key_out onto tone_out. When it is undefined, tone_out is tied low.
module morse_encoder #(
  parameter int unsigned UNIT_CYCLES = 25000000,
  parameter int unsigned TONE_HALF   = 25000
) (
  input  logic       cclk,
  input  logic       rst,
  input  logic [5:0] char_code,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       tone_out,
  output logic       busy,
  output logic       done,
  output logic       bad_char
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MARK     = 3'd2,
    GAP      = 3'd3,
    CHAR_GAP = 3'd4,
    WORD_GAP = 3'd5
  } state_t;

  localparam logic [5:0]  CODE_SPACE = 6'd27;
  localparam logic [31:0] DUR_1U = 32'(UNIT_CYCLES);
  localparam logic [31:0] DUR_3U = 32'(3 * UNIT_CYCLES);
  localparam logic [31:0] DUR_4U = 32'(4 * UNIT_CYCLES);

  // Character table: {len[2:0], pat[4:0]}, pat right-aligned, first element at bit len-1,
  // 1 = dash. len == 0 marks an entry with no elements (word space or unmapped).
  function automatic logic [7:0] code_entry(input logic [5:0] code);
    case (code)
      6'd1:  code_entry = {3'd2, 5'b00001}; // A .-
      6'd2:  code_entry = {3'd4, 5'b01000}; // B -...
      6'd3:  code_entry = {3'd4, 5'b01010}; // C -.-.
      6'd4:  code_entry = {3'd3, 5'b00100}; // D -..
      6'd5:  code_entry = {3'd1, 5'b00000}; // E .
      6'd6:  code_entry = {3'd4, 5'b00010}; // F ..-.
      6'd7:  code_entry = {3'd3, 5'b00110}; // G --.
      6'd8:  code_entry = {3'd4, 5'b00000}; // H ....
      6'd9:  code_entry = {3'd2, 5'b00000}; // I ..
      6'd10: code_entry = {3'd4, 5'b00111}; // J .---
      6'd11: code_entry = {3'd3, 5'b00101}; // K -.-
      6'd12: code_entry = {3'd4, 5'b00100}; // L .-..
      6'd13: code_entry = {3'd2, 5'b00011}; // M --
      6'd14: code_entry = {3'd2, 5'b00010}; // N -.
      6'd15: code_entry = {3'd3, 5'b00111}; // O ---
      6'd16: code_entry = {3'd4, 5'b00110}; // P .--.
      6'd17: code_entry = {3'd4, 5'b01101}; // Q --.-
      6'd18: code_entry = {3'd3, 5'b00010}; // R .-.
      6'd19: code_entry = {3'd3, 5'b00000}; // S ...
      6'd20: code_entry = {3'd1, 5'b00001}; // T -
      6'd21: code_entry = {3'd3, 5'b00001}; // U ..-
      6'd22: code_entry = {3'd4, 5'b00001}; // V ...-
      6'd23: code_entry = {3'd3, 5'b00011}; // W .--
      6'd24: code_entry = {3'd4, 5'b01001}; // X -..-
      6'd25: code_entry = {3'd4, 5'b01011}; // Y -.--
      6'd26: code_entry = {3'd4, 5'b01100}; // Z --..
      6'd28: code_entry = {3'd5, 5'b01111}; // 1 .----
      6'd29: code_entry = {3'd5, 5'b00111}; // 2 ..---
      6'd30: code_entry = {3'd5, 5'b00011}; // 3 ...--
      6'd31: code_entry = {3'd5, 5'b00001}; // 4 ....-
      6'd32: code_entry = {3'd5, 5'b00000}; // 5 .....
      6'd33: code_entry = {3'd5, 5'b10000}; // 6 -....
      6'd34: code_entry = {3'd5, 5'b11000}; // 7 --...
      6'd35: code_entry = {3'd5, 5'b11100}; // 8 ---..
      6'd36: code_entry = {3'd5, 5'b11110}; // 9 ----.
      6'd37: code_entry = {3'd5, 5'b11111}; // 0 -----
      6'd38: code_entry = {3'd5, 5'b10001}; // = -...-
      6'd39: code_entry = {3'd5, 5'b10010}; // / -..-.
      6'd40: code_entry = {3'd5, 5'b01010}; // + .-.-.
      default: code_entry = {3'd0, 5'b00000};
    endcase
  endfunction

  // A code is mapped if it has elements or is the word space.
  function automatic logic code_mapped(input logic [5:0] code);
    code_mapped = (code == CODE_SPACE) || (code_entry(code)[7:5] != 3'd0);
  endfunction

  state_t      state;
  logic [5:0]  code_r;
  logic [4:0]  pat_r;
  logic [2:0]  idx_r;
  logic [31:0] cnt_r;
  logic [7:0]  entry_s;
  logic [31:0] limit_s;
  logic        last_s;
  logic        pre_last_s;

  assign entry_s = code_entry(code_r);

  // Length of the interval currently being timed, and its last/second-to-last cycle flags.
  always_comb begin
    limit_s = DUR_1U;
    case (state)
      MARK:     limit_s = pat_r[idx_r] ? DUR_3U : DUR_1U;
      GAP:      limit_s = DUR_1U;
      CHAR_GAP: limit_s = DUR_3U;
      WORD_GAP: limit_s = DUR_4U;
      default:  limit_s = DUR_1U;
    endcase
    last_s     = (cnt_r == (limit_s - 32'd1));
    pre_last_s = (cnt_r == (limit_s - 32'd2));
  end

  // Main sequencer: accepts a code, looks it up, then times marks and gaps.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      code_r     <= 6'd0;
      pat_r      <= 5'd0;
      idx_r      <= 3'd0;
      cnt_r      <= 32'd0;
      char_ready <= 1'b1;
      busy       <= 1'b0;
      key_out    <= 1'b0;
      done       <= 1'b0;
      bad_char   <= 1'b0;
    end else begin
      done     <= 1'b0;
      bad_char <= 1'b0;
      case (state)
        IDLE: begin
          cnt_r <= 32'd0;
          if (char_valid && char_ready) begin
            code_r     <= char_code;
            state      <= LOAD;
            char_ready <= 1'b0;
            busy       <= 1'b1;
            bad_char   <= ~code_mapped(char_code);
          end
        end
        LOAD: begin
          cnt_r <= 32'd0;
          if (code_r == CODE_SPACE) begin
            state <= WORD_GAP;
          end else if (entry_s[7:5] == 3'd0) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state   <= MARK;
            key_out <= 1'b1;
            pat_r   <= entry_s[4:0];
            idx_r   <= entry_s[7:5] - 3'd1;
          end
        end
        MARK: begin
          if (last_s) begin
            cnt_r   <= 32'd0;
            key_out <= 1'b0;
            if (idx_r == 3'd0) begin
              state <= CHAR_GAP;
            end else begin
              state <= GAP;
              idx_r <= idx_r - 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        GAP: begin
          if (last_s) begin
            cnt_r   <= 32'd0;
            key_out <= 1'b1;
            state   <= MARK;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        CHAR_GAP, WORD_GAP: begin
          // done is registered, so it is raised one cycle early to land on the last gap cycle.
          if (pre_last_s) begin
            done <= 1'b1;
          end
          if (last_s) begin
            cnt_r      <= 32'd0;
            state      <= IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt_r      <= 32'd0;
          key_out    <= 1'b0;
          char_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef MORSE_TONE_EN
  logic [31:0] div_cnt;
  logic        wave;

  // Free-running tone divider; only rst restarts it so the tone phase is independent of keying.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      div_cnt <= 32'd0;
      wave    <= 1'b0;
    end else if (div_cnt == (32'(TONE_HALF) - 32'd1)) begin
      div_cnt <= 32'd0;
      wave    <= ~wave;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  assign tone_out = key_out & wave;
`else
  // No tone generator in this build; TONE_HALF has no effect here.
  assign tone_out = (TONE_HALF == 0) ? 1'b0 : 1'b0;
`endif

endmodule
